// File: rtl/gpio_in_capture_pkg.sv
// Shared definitions for the GPIO input-capture block: register offsets
// (including those of the companion output port) and sizing helpers.
package gpio_in_capture_pkg;

  localparam int GPIO_W = 8;

  // Offsets used by the companion GPIO output port on the same bus.
  localparam logic [2:0] GPIO_OUT_OFS  = 3'd0;
  localparam logic [2:0] GPIO_TRIS_OFS = 3'd1;
  localparam logic [2:0] GPIO_IN_OFS   = 3'd2;

  typedef enum logic [2:0] {
    REG_PIN     = 3'd0,
    REG_RISE_EN = 3'd1,
    REG_FALL_EN = 3'd2,
    REG_FLAG    = 3'd3,
    REG_IE      = 3'd4,
    REG_RAW     = 3'd5
  } gpio_in_reg_e;

  // A one-cycle debounce still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_in_capture_if.sv
// CPU peripheral bus seen by the GPIO input-capture block.
interface gpio_in_capture_if;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wr_en;
  logic       rd_en;

  modport master (output addr, output din, output wr_en, output rd_en, input dout);
  modport slave  (input addr, input din, input wr_en, input rd_en, output dout);
endinterface

// File: rtl/gpio_in_capture_debounce.sv
// One pin: 2-FF synchroniser, stability counter, debounced level and
// single-cycle rise/fall pulses coincident with the level change.
module gpio_in_capture_debounce
  import gpio_in_capture_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_async,
  output logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  assign raw    = sync_p1;
  assign settle = (sync_p1 != level) && (cnt == CNT_LAST);
  assign rise   = settle & sync_p1;
  assign fall   = settle & ~sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sync_p0 <= pin_async;
      sync_p1 <= sync_p0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: debounced pins, sticky edge flags with W1C, per-bit
// interrupt enables and a registered-read register file on the CPU bus.
module gpio_in_capture
  import gpio_in_capture_pkg::*;
#(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 2,
  parameter int DEB_CYCLES        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  gpio_in_capture_if.slave         bus,
  input  logic [GPIO_W-1:0]        pin_in,
  output logic                     irq
);

  localparam int LOC_W = OPT_MEM_ADDR_BITS + 1;

  logic [LOC_W-1:0]  loc_addr;
  logic              unused_addr;
  logic [GPIO_W-1:0] pin, raw, rise, fall;
  logic [GPIO_W-1:0] rise_en, fall_en, flag, ie;
  logic [GPIO_W-1:0] w1c, flag_set, rd_data;

  assign loc_addr    = bus.addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign unused_addr = ^bus.addr;

  for (genvar i = 0; i < GPIO_W; i++) begin : g_bit
    gpio_in_capture_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk       (clk),
      .reset     (reset),
      .pin_async (pin_in[i]),
      .raw       (raw[i]),
      .level     (pin[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  // An edge landing in the same cycle as its W1C survives the clear.
  assign flag_set = (rise & rise_en) | (fall & fall_en);

  always_comb begin
    w1c = '0;
    if (bus.wr_en && (loc_addr == LOC_W'(REG_FLAG))) w1c = bus.din;
  end

  always_comb begin
    rd_data = '0;
    case (loc_addr)
      LOC_W'(REG_PIN):     rd_data = pin;
      LOC_W'(REG_RISE_EN): rd_data = rise_en;
      LOC_W'(REG_FALL_EN): rd_data = fall_en;
      LOC_W'(REG_FLAG):    rd_data = flag;
      LOC_W'(REG_IE):      rd_data = ie;
      LOC_W'(REG_RAW):     rd_data = raw;
      default:             rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en  <= '0;
      fall_en  <= '0;
      flag     <= '0;
      ie       <= '0;
      bus.dout <= '0;
    end else begin
      // register file / read data stage boundary
      if (bus.wr_en) begin
        case (loc_addr)
          LOC_W'(REG_RISE_EN): rise_en <= bus.din;
          LOC_W'(REG_FALL_EN): fall_en <= bus.din;
          LOC_W'(REG_IE):      ie      <= bus.din;
          default: ;
        endcase
      end
      flag <= (flag & ~w1c) | flag_set;
      if (bus.rd_en && !bus.wr_en) bus.dout <= rd_data;
    end
  end

  assign irq = |(flag & ie);

endmodule

// File: tb/tb_gpio_in_capture.sv
// Randomised and directed bench for gpio_in_capture with a cycle-level
// reference model and a read-data scoreboard.
module tb_gpio_in_capture;
  localparam int DEB = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] pin_in = 8'hFF;
  logic       irq;

  gpio_in_capture_if bus ();

  gpio_in_capture #(.ADDR_LSB(0), .OPT_MEM_ADDR_BITS(2), .DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pin_in (pin_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a pin level follows the synchronised input once that
  // input has disagreed with it for DEB consecutive samples.
  logic [7:0] m_pin     = '0;
  logic [7:0] m_rise_en = '0;
  logic [7:0] m_fall_en = '0;
  logic [7:0] m_flag    = '0;
  logic [7:0] m_ie      = '0;
  int         m_run [8];
  logic [7:0] samples [$] = '{8'h00, 8'h00};
  logic [7:0] exp_q [$];
  logic [7:0] exp_hold = '0;

  typedef struct {
    logic       is_irq;
    logic [7:0] val;
    string      name;
  } dchk_t;
  dchk_t dir_q [$];

  function automatic logic [7:0] model_read(input logic [2:0] loc, input logic [7:0] raw);
    case (loc)
      3'd0: return m_pin;
      3'd1: return m_rise_en;
      3'd2: return m_fall_en;
      3'd3: return m_flag;
      3'd4: return m_ie;
      3'd5: return raw;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [7:0] raw_pre, rise, fall, w1c;
    logic [2:0] loc;
    if (reset) begin
      m_pin = '0; m_rise_en = '0; m_fall_en = '0; m_flag = '0; m_ie = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      samples = '{8'h00, 8'h00};
      exp_q.delete();
    end else begin
      samples.push_back(pin_in);
      raw_pre = samples[0];
      void'(samples.pop_front());
      rise = '0;
      fall = '0;
      for (int i = 0; i < 8; i++) begin
        if (raw_pre[i] != m_pin[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_run[i] = 0;
            if (raw_pre[i]) rise[i] = 1'b1;
            else            fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      loc = bus.addr[2:0];
      if (bus.rd_en && !bus.wr_en) exp_q.push_back(model_read(loc, raw_pre));
      w1c    = (bus.wr_en && loc == 3'd3) ? bus.din : 8'h00;
      m_flag = (m_flag & ~w1c) | (rise & m_rise_en) | (fall & m_fall_en);
      if (bus.wr_en) begin
        case (loc)
          3'd1: m_rise_en = bus.din;
          3'd2: m_fall_en = bus.din;
          3'd4: m_ie      = bus.din;
          default: ;
        endcase
      end
      m_pin = m_pin ^ (rise | fall);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs every cycle, away from the active edge.
  always @(negedge clk) begin
    dchk_t d;
    if (reset) exp_hold = 8'h00;
    else if (exp_q.size() > 0) exp_hold = exp_q.pop_front();
    check("dout", bus.dout, exp_hold);
    check("irq", {7'b0, irq}, {7'b0, |(m_flag & m_ie)});
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      if (d.is_irq) check(d.name, {7'b0, irq}, d.val);
      else          check(d.name, bus.dout, d.val);
    end
  end

  task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.addr  = a;
    bus.din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic expect_dout(input string name, input logic [7:0] v);
    dchk_t d;
    d.is_irq = 1'b0; d.val = v; d.name = name;
    dir_q.push_back(d);
  endtask

  task automatic expect_irq(input string name, input logic v);
    dchk_t d;
    d.is_irq = 1'b1; d.val = {7'b0, v}; d.name = name;
    dir_q.push_back(d);
  endtask

  initial begin
    logic [7:0] a, dd;
    int op;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.din = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Pins high out of reset, no edge enables
    idle(6);
    drive(0, 1, 8'h00, 8'h00); expect_dout("pin_after_reset", 8'hFF);
    drive(0, 1, 8'h03, 8'h00); expect_dout("flag_after_reset", 8'h00);
    expect_irq("irq_after_reset", 1'b0);

    // Single rising edge with interrupt, then W1C
    pin_in = 8'h00;
    idle(8);
    drive(1, 0, 8'h01, 8'h01);
    drive(1, 0, 8'h04, 8'h01);
    pin_in = 8'h01;
    idle(6);
    drive(0, 1, 8'h03, 8'h00); expect_dout("flag_rise0", 8'h01); expect_irq("irq_rise0", 1'b1);
    drive(1, 0, 8'h03, 8'h01); expect_irq("irq_after_w1c", 1'b0);

    // Short glitch rejected, qualifying pulse flags both edges
    drive(1, 0, 8'h01, 8'hFF);
    drive(1, 0, 8'h02, 8'hFF);
    drive(1, 0, 8'h03, 8'hFF);
    pin_in[3] = 1'b1; idle(3); pin_in[3] = 1'b0; idle(8);
    drive(0, 1, 8'h03, 8'h00); expect_dout("flag_glitch", 8'h00);
    drive(0, 1, 8'h00, 8'h00); expect_dout("pin_glitch", 8'h01);
    pin_in[3] = 1'b1; idle(4); pin_in[3] = 1'b0; idle(8);
    drive(0, 1, 8'h03, 8'h00); expect_dout("flag_pulse4", 8'h08);

    // W1C colliding with a new rise on bit 2
    pin_in[2] = 1'b1;
    idle(5);
    drive(1, 0, 8'h03, 8'h04);
    drive(0, 1, 8'h03, 8'h00); expect_dout("w1c_set_wins", 8'h0C);

    // Bus corner cases
    drive(1, 1, 8'h01, 8'h5A);
    drive(0, 1, 8'h01, 8'h00); expect_dout("wr_rd_same_cycle", 8'h5A);
    drive(0, 1, 8'h06, 8'h00); expect_dout("addr6_zero", 8'h00);
    drive(1, 0, 8'h00, 8'hAA);
    drive(0, 1, 8'h00, 8'h00); expect_dout("pin_ro", 8'h05);
    drive(0, 1, 8'hFD, 8'h00); expect_dout("raw_upper_addr", 8'h05);

    // Reset in the middle of a debounce
    drive(1, 0, 8'h04, 8'hFF);
    pin_in[5] = 1'b1;
    idle(4);
    reset = 1'b1;
    expect_irq("irq_async_reset", 1'b0);
    expect_dout("dout_async_reset", 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    idle(5);
    drive(0, 1, 8'h00, 8'h00);
    drive(0, 1, 8'h00, 8'h00); expect_dout("pin_requalify", 8'h25);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) pin_in = pin_in ^ (8'h01 << $urandom_range(0, 7));
      op = $urandom_range(0, 3);
      a  = 8'($urandom);
      dd = 8'($urandom);
      case (op)
        0: drive(0, 0, a, dd);
        1: drive(0, 1, a, dd);
        2: drive(1, 0, a, dd);
        default: drive(1, 1, a, dd);
      endcase
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
